// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812 pixel serializer.
package ws2812_pkg;

  localparam int PHASE_W = 8;
  localparam int LATCH_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    LATCH = 3'd4
  } state_t;

  typedef struct packed {
    logic [PHASE_W-1:0] t0h;
    logic [PHASE_W-1:0] t0l;
    logic [PHASE_W-1:0] t1h;
    logic [PHASE_W-1:0] t1l;
    logic [LATCH_W-1:0] rst;
  } timing_t;

  // Typical WS2812B timing at a 50 MHz clock (0.4/0.85 us, 0.8/0.45 us, 300 us latch).
  localparam timing_t TIMING_DEFAULT = '{
    t0h: 8'd20, t0l: 8'd42, t1h: 8'd40, t1l: 8'd22, rst: 16'd15000
  };

  // High-phase length for a data bit.
  function automatic logic [PHASE_W-1:0] high_len(input timing_t t, input logic b);
    return b ? t.t1h : t.t0h;
  endfunction

  // Low-phase length for a data bit.
  function automatic logic [PHASE_W-1:0] low_len(input timing_t t, input logic b);
    return b ? t.t1l : t.t0l;
  endfunction

endpackage

// File: rtl/ws2812_phase_timer.sv
// Loadable down-counter. A load of N runs for max(N,1) cycles; last_cycle
// is high in the final one and stays high while the counter is parked at 0.
module ws2812_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] count,
  output logic         last_cycle
);

  logic [W-1:0] cnt_q;

  // Load count-1 (a zero count behaves as one), otherwise count down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (count == '0) ? '0 : count - W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign last_cycle = (cnt_q == '0);

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// Serializes pixel words MSB first onto a WS2812 line, with a one-word
// holding register for gapless pixels and a latch interval at frame end.
//
// Handshake: a word transfers on a rising clk_in edge where pix_valid_in and
// pix_ready_out are both high; pix_ready_out is high exactly when the holding
// register is empty and does not depend on pix_valid_in.
module ws2812_pixel_serializer
  import ws2812_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [7:0]        t0h_cnt_in,
  input  logic [7:0]        t0l_cnt_in,
  input  logic [7:0]        t1h_cnt_in,
  input  logic [7:0]        t1l_cnt_in,
  input  logic [15:0]       rst_cnt_in,
  input  logic              pix_valid_in,
  input  logic [DATA_W-1:0] pix_data_in,
  input  logic              pix_last_in,
  output logic              pix_ready_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              underrun_out,
  output logic              ws2812_data_out,
  output state_t            dbg_state
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

  state_t              state_q, state_n;
  timing_t             cfg_in, cfg_q;
  logic                hold_vld_q, hold_last_q;
  logic [DATA_W-1:0]   hold_data_q, shift_q;
  logic [IDX_W-1:0]    idx_q;
  logic                word_last_q, line_q;
  logic                accept, hold_free, snap, load_shift_hold, shift_adv;
  logic                load_phase, load_latch, phase_last, latch_last;
  logic [PHASE_W-1:0]  phase_val;
  logic                done_p, underrun_p;

  assign cfg_in = '{t0h: t0h_cnt_in, t0l: t0l_cnt_in, t1h: t1h_cnt_in,
                    t1l: t1l_cnt_in, rst: rst_cnt_in};
  assign accept = pix_valid_in && !hold_vld_q;

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next state and datapath control; the current bit is always shift_q's MSB.
  always_comb begin
    state_n         = state_q;
    snap            = 1'b0;
    load_shift_hold = 1'b0;
    shift_adv       = 1'b0;
    hold_free       = 1'b0;
    load_phase      = 1'b0;
    phase_val       = '0;
    load_latch      = 1'b0;
    done_p          = 1'b0;
    underrun_p      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_vld_q) begin
          state_n = LOAD;
          snap    = 1'b1;
        end
      end
      LOAD: begin
        state_n         = HIGH;
        load_shift_hold = 1'b1;
        hold_free       = 1'b1;
        load_phase      = 1'b1;
        phase_val       = high_len(cfg_q, hold_data_q[DATA_W-1]);
      end
      HIGH: begin
        if (phase_last) begin
          state_n    = LOW;
          load_phase = 1'b1;
          phase_val  = low_len(cfg_q, shift_q[DATA_W-1]);
        end
      end
      LOW: begin
        if (phase_last) begin
          if (idx_q != '0) begin
            state_n    = HIGH;
            shift_adv  = 1'b1;
            load_phase = 1'b1;
            phase_val  = high_len(cfg_q, shift_q[DATA_W-2]);
          end else if (word_last_q) begin
            state_n    = LATCH;
            load_latch = 1'b1;
          end else if (hold_vld_q) begin
            // Gapless: next pixel goes straight from holding register to HIGH.
            state_n         = HIGH;
            load_shift_hold = 1'b1;
            hold_free       = 1'b1;
            load_phase      = 1'b1;
            phase_val       = high_len(cfg_q, hold_data_q[DATA_W-1]);
          end else begin
            state_n    = LATCH;
            load_latch = 1'b1;
            underrun_p = 1'b1;
          end
        end
      end
      LATCH: begin
        if (latch_last) begin
          state_n = IDLE;
          done_p  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register, shift register, config snapshot and registered line.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_vld_q  <= 1'b0;
      hold_last_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      word_last_q <= 1'b0;
      cfg_q       <= TIMING_DEFAULT;
      line_q      <= 1'b0;
    end else begin
      line_q <= (state_n == HIGH);
      if (snap) cfg_q <= cfg_in;
      if (accept) begin
        hold_vld_q  <= 1'b1;
        hold_data_q <= pix_data_in;
        hold_last_q <= pix_last_in;
      end else if (hold_free) begin
        hold_vld_q <= 1'b0;
      end
      if (load_shift_hold) begin
        shift_q     <= hold_data_q;
        idx_q       <= IDX_TOP;
        word_last_q <= hold_last_q;
      end else if (shift_adv) begin
        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        idx_q   <= idx_q - IDX_W'(1);
      end
    end
  end

  ws2812_phase_timer #(.W(PHASE_W)) u_phase_timer (
    .clk        (clk_in),
    .rst        (rst_in),
    .load       (load_phase),
    .count      (phase_val),
    .last_cycle (phase_last)
  );

  ws2812_phase_timer #(.W(LATCH_W)) u_latch_timer (
    .clk        (clk_in),
    .rst        (rst_in),
    .load       (load_latch),
    .count      (cfg_q.rst),
    .last_cycle (latch_last)
  );

  assign pix_ready_out   = !hold_vld_q;
  assign busy_out        = (state_q != IDLE);
  assign done_out        = done_p;
  assign underrun_out    = underrun_p;
  assign ws2812_data_out = line_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Self-checking bench for ws2812_pixel_serializer: single-frame vector table
// plus streaming, underrun, mid-frame config change and mid-frame reset.
module tb_ws2812_pixel_serializer;
  import ws2812_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic [7:0]  t0h_cnt_in = '0, t0l_cnt_in = '0, t1h_cnt_in = '0, t1l_cnt_in = '0;
  logic [15:0] rst_cnt_in = '0;
  logic        pix_valid_in = 1'b0;
  logic [23:0] pix_data_in = '0;
  logic        pix_last_in = 1'b0;
  logic        pix_ready_out, busy_out, done_out, underrun_out, ws2812_data_out;
  state_t      dbg_state;

  ws2812_pixel_serializer #(.DATA_W(24)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .t0h_cnt_in      (t0h_cnt_in),
    .t0l_cnt_in      (t0l_cnt_in),
    .t1h_cnt_in      (t1h_cnt_in),
    .t1l_cnt_in      (t1l_cnt_in),
    .rst_cnt_in      (rst_cnt_in),
    .pix_valid_in    (pix_valid_in),
    .pix_data_in     (pix_data_in),
    .pix_last_in     (pix_last_in),
    .pix_ready_out   (pix_ready_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .underrun_out    (underrun_out),
    .ws2812_data_out (ws2812_data_out),
    .dbg_state       (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  // ---------------- scoreboard: one entry {high_len, low_len} per bit ----------------
  logic [31:0] exp_q[$];

  function automatic void push_word(input logic [23:0] d, input timing_t c, input bit ends_frame);
    int hi, lo;
    for (int i = 23; i >= 0; i--) begin
      hi = d[i] ? eff(c.t1h) : eff(c.t0h);
      lo = d[i] ? eff(c.t1l) : eff(c.t0l);
      if (i == 0 && ends_frame) lo += eff(c.rst);
      exp_q.push_back({hi[15:0], lo[15:0]});
    end
  endfunction

  task automatic check_pair(input int hi, input int lo);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk("bit_unexpected", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("bit_high_len", hi, {16'd0, e[31:16]});
      chk("bit_low_len", lo, {16'd0, e[15:0]});
    end
  endtask

  // ---------------- line monitor and event counters ----------------
  int mon = 0, hi_len = 0, lo_len = 0;
  int done_cnt = 0, done_cyc = 0, underrun_cnt = 0, ready_falls = 0;
  logic ready_prev = 1'b1;

  always @(negedge clk_in) begin
    if (rst_in) begin
      mon = 0; hi_len = 0; lo_len = 0;
    end else begin
      case (mon)
        0: if (ws2812_data_out) begin mon = 1; hi_len = 1; end
        1: if (ws2812_data_out) hi_len++;
           else begin
             mon = 2; lo_len = 1;
             if (done_out) begin check_pair(hi_len, lo_len); mon = 0; end
           end
        default: if (ws2812_data_out) begin
             check_pair(hi_len, lo_len); mon = 1; hi_len = 1;
           end else begin
             lo_len++;
             if (done_out) begin check_pair(hi_len, lo_len); mon = 0; end
           end
      endcase
    end
    if (done_out) begin done_cnt++; done_cyc = cyc; end
    if (underrun_out) underrun_cnt++;
    if (ready_prev && !pix_ready_out) ready_falls++;
    ready_prev = pix_ready_out;
  end

  // ---------------- driver tasks (entered at a negedge) ----------------
  task automatic set_cfg(input timing_t c);
    t0h_cnt_in = c.t0h; t0l_cnt_in = c.t0l; t1h_cnt_in = c.t1h;
    t1l_cnt_in = c.t1l; rst_cnt_in = c.rst;
  endtask

  task automatic send(input logic [23:0] d, input logic l, output int acc);
    int g = 0;
    pix_valid_in = 1'b1; pix_data_in = d; pix_last_in = l;
    while (!pix_ready_out && g < 5000) begin @(negedge clk_in); g++; end
    if (!pix_ready_out) chk("send_ready_timeout", 0, 1);
    @(posedge clk_in);
    @(negedge clk_in);
    acc = cyc;
    pix_valid_in = 1'b0; pix_last_in = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input int bound);
    int g = 0;
    while (done_cnt == start_cnt && g < bound) begin @(posedge clk_in); g++; end
    if (done_cnt == start_cnt) chk("done_timeout", 0, 1);
    @(negedge clk_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    timing_t     cfg;
    logic [23:0] data;
    int          exp_lat;   // cycles from accept edge to the done_out cycle
  } vec_t;
  vec_t vecs[5];

  initial begin
    int acc, acc2, d0, u0, r0;
    timing_t c5, c9, c1;

    // latency = 2 + 24*bit_period + rst - 1 (all periods uniform per row)
    vecs[0] = '{cfg: '{t0h:8'd2, t0l:8'd5, t1h:8'd5, t1l:8'd2, rst:16'd10}, data: 24'hA50000, exp_lat: 179};
    vecs[1] = '{cfg: '{t0h:8'd0, t0l:8'd0, t1h:8'd0, t1l:8'd0, rst:16'd0},  data: 24'h123456, exp_lat: 50};
    vecs[2] = '{cfg: '{t0h:8'd1, t0l:8'd3, t1h:8'd3, t1l:8'd1, rst:16'd4},  data: 24'hFFFFFF, exp_lat: 101};
    vecs[3] = '{cfg: '{t0h:8'd3, t0l:8'd1, t1h:8'd1, t1l:8'd3, rst:16'd1},  data: 24'h000001, exp_lat: 98};
    vecs[4] = '{cfg: '{t0h:8'd4, t0l:8'd4, t1h:8'd2, t1l:8'd6, rst:16'd20}, data: 24'h5A5A5A, exp_lat: 213};
    c5 = vecs[0].cfg;
    c9 = c5; c9.t1h = 8'd9;
    c1 = '{t0h:8'd1, t0l:8'd1, t1h:8'd1, t1l:8'd1, rst:16'd5};

    // reset state
    repeat (3) @(negedge clk_in);
    chk("rst_line", ws2812_data_out, 0);
    chk("rst_ready", pix_ready_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_underrun", underrun_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // single-word frames from the table
    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i].cfg);
      push_word(vecs[i].data, vecs[i].cfg, 1'b1);
      d0 = done_cnt; u0 = underrun_cnt;
      send(vecs[i].data, 1'b1, acc);
      wait_done(d0, 3000);
      chk($sformatf("vec%0d_done_lat", i), done_cyc - acc, vecs[i].exp_lat);
      chk($sformatf("vec%0d_underrun", i), underrun_cnt - u0, 0);
      chk($sformatf("vec%0d_idle_busy", i), busy_out, 0);
      chk($sformatf("vec%0d_idle_line", i), ws2812_data_out, 0);
    end

    // three words streamed back to back
    set_cfg(c5);
    push_word(24'hC0FFEE, c5, 1'b0);
    push_word(24'h3C0F81, c5, 1'b0);
    push_word(24'h800001, c5, 1'b1);
    d0 = done_cnt; u0 = underrun_cnt; r0 = ready_falls;
    send(24'hC0FFEE, 1'b0, acc);
    send(24'h3C0F81, 1'b0, acc2);
    send(24'h800001, 1'b1, acc2);
    wait_done(d0, 3000);
    chk("stream_done_lat", done_cyc - acc, 2 + 72 * 7 + 10 - 1);
    chk("stream_ready_falls", ready_falls - r0, 3);
    chk("stream_underrun", underrun_cnt - u0, 0);

    // starved frame: underrun ends it, late word starts a fresh frame
    set_cfg(c1);
    push_word(24'h0F0F0F, c1, 1'b1);
    d0 = done_cnt; u0 = underrun_cnt;
    send(24'h0F0F0F, 1'b0, acc);
    wait_done(d0, 3000);
    chk("underrun_done_lat", done_cyc - acc, 2 + 48 + 5 - 1);
    chk("underrun_pulses", underrun_cnt - u0, 1);
    push_word(24'hF00001, c1, 1'b1);
    d0 = done_cnt;
    send(24'hF00001, 1'b1, acc);
    wait_done(d0, 3000);
    chk("late_word_done_lat", done_cyc - acc, 2 + 48 + 5 - 1);
    chk("late_word_underrun", underrun_cnt - u0, 1);

    // t1h changed mid-frame takes effect on the next frame only
    set_cfg(c5);
    push_word(24'hFFFFFF, c5, 1'b1);
    d0 = done_cnt;
    send(24'hFFFFFF, 1'b1, acc);
    repeat (20) @(negedge clk_in);
    set_cfg(c9);
    wait_done(d0, 3000);
    chk("cfg_old_done_lat", done_cyc - acc, 179);
    push_word(24'hFFFFFF, c9, 1'b1);
    d0 = done_cnt;
    send(24'hFFFFFF, 1'b1, acc);
    wait_done(d0, 3000);
    chk("cfg_new_done_lat", done_cyc - acc, 2 + 24 * 11 + 10 - 1);

    // reset during a HIGH phase
    set_cfg(c5);
    push_word(24'hFFFFFF, c5, 1'b1);
    d0 = done_cnt;
    send(24'hFFFFFF, 1'b1, acc);
    repeat (10) @(negedge clk_in);
    chk("pre_reset_line", ws2812_data_out, 1);
    rst_in = 1'b1;
    #1;
    chk("mid_reset_line", ws2812_data_out, 0);
    chk("mid_reset_ready", pix_ready_out, 1);
    chk("mid_reset_busy", busy_out, 0);
    repeat (2) @(negedge clk_in);
    exp_q.delete();
    rst_in = 1'b0;
    repeat (200) @(negedge clk_in);
    chk("mid_reset_no_done", done_cnt - d0, 0);
    set_cfg(vecs[2].cfg);
    push_word(24'h6B1D2E, vecs[2].cfg, 1'b1);
    send(24'h6B1D2E, 1'b1, acc);
    wait_done(d0, 3000);
    chk("post_reset_done_lat", done_cyc - acc, 101);

    repeat (5) @(negedge clk_in);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_pixel_serializer.md
# ws2812_pixel_serializer

Converts a stream of pixel words into a WS2812 single-wire waveform using the runtime bit-timing counts from `layer_cfg`. It sits between the per-channel pixel buffer read port, which is the producer, and the `ws2812_data_out` pin of one output channel. It is the consuming stage for both the pixel data and the timing configuration. It provides gapless back-to-back pixel output through a one-word holding register, and appends a latch (reset) interval at end of frame.

## Interface
Parameters:
- `DATA_W`, default 24: bits per pixel (24 GRB; 32 for RGBW strips).

Ports (all signals synchronous to `clk_in`; one clock; reset is asynchronous and active-high):
- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `t0h_cnt_in`, `t0l_cnt_in`, `t1h_cnt_in`, `t1l_cnt_in` in 8 each: high/low phase lengths in cycles for bit 0 and bit 1.
- `rst_cnt_in` in 16: latch interval in cycles.
- `pix_valid_in` in 1: pixel word offered.
- `pix_data_in` in `DATA_W`: pixel word, transmitted MSB first.
- `pix_last_in` in 1: qualifies the word as the last of the frame.
- `pix_ready_out` out 1: holding register empty.
- `busy_out` out 1: high in any state other than IDLE.
- `done_out` out 1: one-cycle pulse when the latch interval completes.
- `underrun_out` out 1: one-cycle pulse when a frame is ended by starvation.
- `ws2812_data_out` out 1: registered line output.

## Operation
- Handshake: a word transfers on `pix_valid_in & pix_ready_out`. `pix_ready_out` = !`hold_vld`. `pix_data_in` and `pix_last_in` are captured into the holding register.
- FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE -> LOAD when `hold_vld`. The four timing counts and `rst_cnt_in` are snapshotted at this point, so config writes mid-frame take effect at the next frame.
- LOAD: the holding word moves into the shift register and the bit index is set to `DATA_W-1`. The holding register frees. Next state is HIGH.
- HIGH: the line is driven 1 for th cycles. th is t1h if the current bit is 1, else t0h. Next state is LOW.
- LOW: the line is driven 0 for tl cycles. tl is t1l if the current bit is 1, else t0l. On the final LOW cycle:
  - If the bit index is above 0: decrement the index, shift, and go to HIGH.
  - If the index is 0 and the current word had last set: go to LATCH.
  - If the index is 0 and `hold_vld` is set: reload the shift register directly from the holding register, free it, and go to HIGH. No LOAD cycle is spent (gapless).
  - If the index is 0 and no word is waiting: pulse `underrun_out` and go to LATCH.
- LATCH: the line is held 0 for the snapshotted `rst_cnt` cycles. On the final cycle, pulse `done_out` and go to IDLE.
- Width rules:
  - Any count of 0 is treated as 1, so the minimum phase is 1 cycle.
  - Phase counters are 8 bits; the latch counter is 16 bits. Counters are down-counters loaded with count−1.
- The holding register may accept the next frame's first word during LATCH. That word is not consumed until IDLE is reached.

## Timing
- Reset values:
  - `ws2812_data_out` = 0, `pix_ready_out` = 1.
  - `busy_out`, `done_out`, `underrun_out` = 0.
  - State is IDLE.
- Reset mid-frame forces the line low immediately through the asynchronous reset. The holding and shift contents are discarded, and no `done_out` pulse is produced.
- Latency: for a word accepted at edge N into an idle block, the line rises at edge N+2 (one cycle for hold capture, one for LOAD).
- Bit period is exactly th+tl cycles. Successive bits and pixels are back-to-back with zero idle cycles.
- Frame end: the line falls at the end of the last bit's LOW phase, then stays low for `rst_cnt` cycles. `done_out` is asserted in the last of those cycles, and IDLE is reached on the next edge.
- Valid and last arriving simultaneously with the final LOW cycle of the previous word: the word is captured that edge. The reload takes the previous contents of the holding register (empty), so an underrun results. The producer must present the next word at least one cycle before the boundary.

## Structure
- Shared package `ws2812_pkg`:
  - `state_t` enum (IDLE, LOAD, HIGH, LOW, LATCH).
  - `timing_t` struct (t0h, t0l, t1h, t1l, rst).
  - Default timing constants.
- One sub-module, `ws2812_phase_timer`: a loadable down-counter with zero-clamp and a `last_cycle` flag. It is instantiated for phase timing, and for latch timing at width 16.

## Test plan
- t0h=2, t0l=5, t1h=5, t1l=2, rst=10; single word 0xA50000 with last -> line shows pattern 1,0,1,0,0,1,0,1 then 16 zero-bits, 7 cycles each; then 10 low cycles; `done_out` asserted at cycle 2+24·7+10−1 after acceptance.
- Three words streamed with valid held high -> no gap between pixels: 72 bit periods contiguous, `pix_ready_out` toggles once per word, no `underrun_out`.
- Second word withheld until after the first finishes -> `underrun_out` pulses once, LATCH runs, and the late word starts a new frame from IDLE.
- All counts = 0 -> every phase lasts 1 cycle, so the bit period is 2 cycles; latch is 1 cycle.
- t1h changed from 5 to 9 mid-frame -> the current frame keeps 5; the next frame uses 9.
- `rst_in` asserted during a HIGH phase -> line is 0 in the same cycle, `pix_ready_out` = 1, no `done_out`, and the next frame proceeds normally.
